// File: rtl/add16_seq_ctrl.sv
// Nibble-serial adder: one 4-bit slice reused per cycle to add two WIDTH-bit
// operands over WIDTH/4 cycles, with an IDLE/ADD/DONE handshake.
module add16_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, a_n, b_r, b_n, s_n;
  logic             carry, carry_n, cout_n;
  logic [IW-1:0]    idx, idx_n;
  logic [IW+1:0]    sh;
  logic [3:0]       x4, y4;
  logic [4:0]       sum5;

  // Single shared 4-bit slice; the index selects which nibble it sees.
  assign sh   = {idx, 2'b00};
  assign x4   = 4'(a_r >> sh);
  assign y4   = 4'(b_r >> sh);
  assign sum5 = {1'b0, x4} + {1'b0, y4} + 5'(carry);

  assign ready = (state != ADD);
  assign busy  = (state == ADD);
  assign done  = (state == DONE);

  always_comb begin
    state_n = state;
    a_n     = a_r;
    b_n     = b_r;
    s_n     = s;
    carry_n = carry;
    cout_n  = cout;
    idx_n   = idx;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_n     = a;
          b_n     = b;
          carry_n = cin;
          s_n     = '0;
          cout_n  = 1'b0;
          idx_n   = '0;
          state_n = ADD;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      ADD: begin
        s_n     = (s & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(sum5[3:0]) << sh);
        carry_n = sum5[4];
        if (idx == IW'(NIBBLES - 1)) begin
          cout_n  = sum5[4];
          state_n = DONE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      s     <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      idx   <= '0;
    end else begin
      state <= state_n;
      a_r   <= a_n;
      b_r   <= b_n;
      s     <= s_n;
      carry <= carry_n;
      cout  <= cout_n;
      idx   <= idx_n;
    end
  end

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Self-checking bench for add16_seq_ctrl: directed cases plus random operands
// checked against a plain-arithmetic reference (A + B + cin).
module tb_add16_seq_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LAT   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n, start, cin;
  logic [WIDTH-1:0] a, b;
  logic             ready, busy, done, cout;
  logic [WIDTH-1:0] s;

  int checks = 0;
  int fails  = 0;

  add16_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .s(s), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Caller sets start/operands at a negedge; returns at the negedge where done
  // is seen. With disturb set, start is pulsed and operands scrambled mid-op.
  task automatic run_op(input bit disturb, output int lat, output bit ok,
                        output bit handshake_ok);
    int n = 0;
    ok = 1'b0;
    handshake_ok = 1'b1;
    @(posedge clk);
    while (n < 20) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (ready !== 1'b0 || busy !== 1'b1) handshake_ok = 1'b0;
      start = 1'b0;
      if (disturb) begin
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        start = (n == 1);
      end
      @(posedge clk);
      n++;
    end
    start = 1'b0;
    lat = n;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #3;
    checks++;
    if ({ready, busy, done, cout, s} !== {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b busy=%b done=%b cout=%b s=%h, want 1 0 0 0 0000",
               ready, busy, done, cout, s);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] ta [5] = '{16'h0005, 16'h0003, 16'h0008, 16'hFFFF, 16'h8000};
    logic [WIDTH-1:0] tb [5] = '{16'h0004, 16'h0009, 16'h0009, 16'h0001, 16'h9000};
    logic             tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [WIDTH:0]   want [5] = '{17'h00009, 17'h0000D, 17'h00011, 17'h10000, 17'h11001};
    int lat; bit ok, hs;
    for (int i = 0; i < 5; i++) begin
      a = ta[i]; b = tb[i]; cin = tc[i]; start = 1'b1;
      run_op(1'b0, lat, ok, hs);
      checks++;
      if (!ok || lat != LAT) begin
        fails++;
        $display("FAIL directed_latency[%0d]: got ok=%0b lat=%0d, want lat=%0d", i, ok, lat, LAT);
      end
      checks++;
      if ({cout, s} !== want[i]) begin
        fails++;
        $display("FAIL directed_sum[%0d]: got cout=%b s=%h, want cout=%b s=%h",
                 i, cout, s, want[i][WIDTH], want[i][WIDTH-1:0]);
      end
      checks++;
      if (!hs) begin
        fails++;
        $display("FAIL directed_busy[%0d]: ready/busy wrong during ADD, want ready=0 busy=1", i);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || {cout, s} !== want[i]) begin
        fails++;
        $display("FAIL directed_hold[%0d]: got done=%b ready=%b cout=%b s=%h", i, done, ready, cout, s);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH:0] w2;
    int lat; bit ok, hs;
    a = 16'h8000; b = 16'h9000; cin = 1'b1; start = 1'b1;
    run_op(1'b0, lat, ok, hs);
    checks++;
    if (!ok || {cout, s} !== 17'h11001) begin
      fails++;
      $display("FAIL b2b_first: got ok=%0b cout=%b s=%h, want cout=1 s=1001", ok, cout, s);
    end
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); start = 1'b1;
    w2 = ref_sum(a, b, cin);
    run_op(1'b0, lat, ok, hs);
    checks++;
    if (!ok || lat != LAT || {cout, s} !== w2) begin
      fails++;
      $display("FAIL b2b_second: got ok=%0b lat=%0d cout=%b s=%h, want lat=%0d cout=%b s=%h",
               ok, lat, cout, s, LAT, w2[WIDTH], w2[WIDTH-1:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    logic [WIDTH:0] w;
    int lat, extra; bit ok, hs;
    a = 16'h1234; b = 16'h0FCD; cin = 1'b1; start = 1'b1;
    w = ref_sum(a, b, cin);
    run_op(1'b1, lat, ok, hs);
    checks++;
    if (!ok || lat != LAT || {cout, s} !== w) begin
      fails++;
      $display("FAIL ignore_start_sum: got ok=%0b lat=%0d cout=%b s=%h, want lat=%0d cout=%b s=%h",
               ok, lat, cout, s, LAT, w[WIDTH], w[WIDTH-1:0]);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0 || {cout, s} !== w) begin
      fails++;
      $display("FAIL ignore_start_single_done: got extra_done=%0d cout=%b s=%h, want 0 and held sum",
               extra, cout, s);
    end
  endtask

  task automatic test_reset_mid;
    logic [WIDTH:0] w;
    int lat, seen; bit ok, hs;
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, done, cout, s} !== {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      fails++;
      $display("FAIL reset_mid_outputs: got ready=%b busy=%b done=%b cout=%b s=%h, want 1 0 0 0 0000",
               ready, busy, done, cout, s);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got %0d done cycles, want 0", seen);
    end
    a = 16'h7FFF; b = 16'h0001; cin = 1'b1; start = 1'b1;
    w = ref_sum(a, b, cin);
    run_op(1'b0, lat, ok, hs);
    checks++;
    if (!ok || lat != LAT || {cout, s} !== w) begin
      fails++;
      $display("FAIL reset_mid_recover: got ok=%0b lat=%0d cout=%b s=%h, want lat=%0d cout=%b s=%h",
               ok, lat, cout, s, LAT, w[WIDTH], w[WIDTH-1:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [WIDTH:0] w;
    int lat; bit ok, hs;
    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); start = 1'b1;
      if (i % 8 == 0) b = ~a;
      w = ref_sum(a, b, cin);
      run_op(1'b0, lat, ok, hs);
      checks++;
      if (!ok || lat != LAT || !hs || {cout, s} !== w) begin
        fails++;
        $display("FAIL random_sum[%0d]: a=%h b=%h cin=%b got ok=%0b lat=%0d hs=%0b cout=%b s=%h, want cout=%b s=%h",
                 i, dut.a_r, dut.b_r, cin, ok, lat, hs, cout, s, w[WIDTH], w[WIDTH-1:0]);
      end
      // Idle gap with wiggling operands: result must hold.
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        a = WIDTH'($urandom); b = WIDTH'($urandom);
      end
      checks++;
      if ({cout, s} !== w || ready !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL random_hold[%0d]: got cout=%b s=%h ready=%b done=%b, want cout=%b s=%h",
                 i, cout, s, ready, done, w[WIDTH], w[WIDTH-1:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
